bus_fabric: RTL



---
 rtl/bus_fabric.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// ---------------------------------------------------------------------------
// bus_fabric
//   Single-master, N-slave system bus interconnect. Each master request is
//   decoded against a programmable base/mask address map. Exactly one slave
//   chip-select is driven, and the fabric waits for that slave's ready
//   handshake, so slaves may insert wait states. A registered response
//   returns read data and an error flag. The error flag is raised for an
//   unmapped address or when a slave exceeds the response timeout.
//
// Ports
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   m_req_i              master request (held stable until m_ready_o)
//   m_we_i               1 = write, 0 = read
//   m_addr_i/m_wdata_i   byte address / write data
//   m_hb_i               access size code, passed through unchanged
//   m_ready_o            one-cycle response strobe
//   m_rdata_o            read data (valid with m_ready_o, held afterwards)
//   m_err_o              error response, qualified by m_ready_o
//   s_cs_o               one-hot slave select
//   s_we_o               write enable, only high while a select is high
//   s_addr_o/s_wdata_o   registered address / write data
//   s_hb_o               registered size code
//   s_rdata_i            flattened slave read data, slave k at [32k+31:32k]
//   s_ready_i            per-slave ready
// ---------------------------------------------------------------------------
module bus_fabric #(
    parameter int                      N_SLAVES   = 3,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter int                      TIMEOUT    = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     m_req_i,
    input  logic                     m_we_i,
    input  logic [31:0]              m_addr_i,
    input  logic [31:0]              m_wdata_i,
    input  logic [1:0]               m_hb_i,
    output logic                     m_ready_o,
    output logic [31:0]              m_rdata_o,
    output logic                     m_err_o,
    output logic [N_SLAVES-1:0]      s_cs_o,
    output logic                     s_we_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_wdata_o,
    output logic [1:0]               s_hb_o,
    input  logic [N_SLAVES*32-1:0]   s_rdata_i,
    input  logic [N_SLAVES-1:0]      s_ready_i
);

    // Wide enough to hold TIMEOUT. With the timeout disabled the counter
    // still runs but saturates, so it never wraps.
    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_SAT = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e               state_q, state_d;
    logic [N_SLAVES-1:0]  cs_q, cs_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [1:0]           hb_q, hb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [N_SLAVES-1:0]  hit_cs;
    logic [31:0]          sel_rdata;
    logic                 sel_ready;

    // Address decode. Scanning from the top index down lets the lowest
    // matching slave overwrite any higher match, giving fixed priority.
    always_comb begin
        hit_cs = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((m_addr_i & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                hit_cs    = '0;
                hit_cs[k] = 1'b1;
            end
        end
    end

    // The one-hot select is an AND-OR mux, so no encoded index is needed.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (cs_q[k]) begin
                sel_rdata = sel_rdata | s_rdata_i[32*k +: 32];
            end
        end
    end

    assign sel_ready = |(s_ready_i & cs_q);

    // NOTE: every signal driven here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hb_d    = hb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    if (|hit_cs) begin
                        addr_d  = m_addr_i;
                        wdata_d = m_wdata_i;
                        hb_d    = m_hb_i;
                        we_d    = m_we_i;
                        cs_d    = hit_cs;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        // Unmapped: no select is raised, so a write is dropped.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Ready is tested first, so it beats a simultaneous timeout.
                if (sel_ready) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                    cs_d    = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_SAT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cs_d    = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the address/data holding registers are reset along with the
    // control state, because every output must read 0 during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cs_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hb_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // same pre-edge values, independent of statement order.
            state_q <= state_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hb_q    <= hb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_ready_o = (state_q == RESP);
    assign m_rdata_o = rdata_q;
    assign m_err_o   = err_q;
    assign s_cs_o    = cs_q;
    assign s_we_o    = we_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
    assign s_hb_o    = hb_q;

endmodule
